seq_mult_16b: RTL and testbench



---
 rtl/seq_mult_16b.sv | 115 +++++++++++
 tb/tb_seq_mult_16b.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seq_mult_16b.sv
// Unsigned 16x16 shift-and-add multiplier, 16 iterations through a single rca_16b.
// Optional SEQ_MULT_ZERO_SKIP_EN: zero operands bypass iteration and go straight to DONE.

module rca_16b (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C_in,
  output logic [15:0] S,
  output logic        C_out
);

  always_comb begin
    logic [16:0] c;
    c    = '0;
    S    = '0;
    c[0] = C_in;
    for (int unsigned i = 0; i < 16; i++) begin
      S[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
    end
    C_out = c[16];
  end

endmodule

module seq_mult_16b #(
  parameter int unsigned N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nx;
  logic [15:0] mcand, hi, lo;
  logic [15:0] addend, sum;
  logic        cout;
  logic [4:0]  cnt;
  logic        accept, zero_op;

  assign addend = lo[0] ? mcand : '0;

  rca_16b u_add (
    .A     (hi),
    .B     (addend),
    .C_in  (1'b0),
    .S     (sum),
    .C_out (cout)
  );

  always_comb begin
`ifdef SEQ_MULT_ZERO_SKIP_EN
    zero_op = (A == '0) || (B == '0);
`else
    zero_op = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept   = 1'b1;
        state_nx = zero_op ? DONE : BUSY;
      end
      BUSY: if (cnt == 5'd15) state_nx = DONE;
      DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = zero_op ? DONE : BUSY;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Carry-out is shifted into hi[15], so the 17-bit partial sum never overflows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else if (accept) begin
      mcand <= A;
      hi    <= '0;
      lo    <= zero_op ? '0 : B;
      cnt   <= '0;
    end else if (state == BUSY) begin
      hi    <= {cout, sum[15:1]};
      lo    <= {sum[0], lo[15:1]};
      cnt   <= cnt + 5'd1;
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);
  assign P    = {hi, lo};

endmodule

// File: tb/tb_seq_mult_16b.sv
// Directed self-checking bench for seq_mult_16b; inputs change on the falling edge, outputs sampled there too.

module tb_seq_mult_16b;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A, B;
  logic        busy, done;
  logic [31:0] P;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SEQ_MULT_ZERO_SKIP_EN
  localparam int ZERO_LAT  = 1;
  localparam int ZERO_BUSY = 0;
`else
  localparam int ZERO_LAT  = 17;
  localparam int ZERO_BUSY = 16;
`endif

  seq_mult_16b #(.N(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: accepts a/b on the next rising edge, then waits for done.
  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] exp_p, input int exp_lat, input int exp_busy);
    int lat, nbusy, both;
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = ~b;
    lat = 1; nbusy = 0; both = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (busy && done) both++;
    chk({tag, "_lat"},  32'(lat),   32'(exp_lat));
    chk({tag, "_busy"}, 32'(nbusy), 32'(exp_busy));
    chk({tag, "_both"}, 32'(both),  32'd0);
    chk({tag, "_P"},    P,          exp_p);
  endtask

  initial begin
    int lat, nbusy;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_P",    P,             32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // basic 3*5
    run("m3x5", 16'h0003, 16'h0005, 32'h0000000F, 17, 16);
    @(negedge clk);
    chk("m3x5_idle_busy", {31'd0, busy}, 32'd0);
    chk("m3x5_idle_done", {31'd0, done}, 32'd0);
    chk("m3x5_hold_P",    P,             32'h0000000F);

    // carry out on every iteration
    run("mffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17, 16);
    @(negedge clk);

    // start re-pulsed mid-BUSY with different operands
    A = 16'h1234; B = 16'hABCD; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1; nbusy = 0;
    repeat (5) begin
      if (busy) nbusy++;
      @(negedge clk); lat++;
    end
    A = 16'h5555; B = 16'h0002; start = 1'b1;
    if (busy) nbusy++;
    @(negedge clk); lat++;
    start = 1'b0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk); lat++;
    end
    chk("repulse_lat",  32'(lat),   32'd17);
    chk("repulse_busy", 32'(nbusy), 32'd16);
    chk("repulse_P",    P,          32'h0C374FA4);
    @(negedge clk);

    // back-to-back with start held in DONE
    A = 16'h0010; B = 16'h0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    chk("b2b1_lat", 32'(lat), 32'd17);
    chk("b2b1_P",   P,        32'h00000100);
    A = 16'h8000; B = 16'h0002; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_idle", {31'd0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    chk("b2b2_lat", 32'(lat), 32'd17);
    chk("b2b2_P",   P,        32'h00010000);
    @(negedge clk);

    // asynchronous reset at iteration 8
    A = 16'h00FF; B = 16'h00FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_P",    P,             32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_done", {31'd0, done}, 32'd0);
    run("m2x7", 16'h0002, 16'h0007, 32'h0000000E, 17, 16);
    @(negedge clk);

    // zero operand
    run("m0x1234", 16'h0000, 16'h1234, 32'h0, ZERO_LAT, ZERO_BUSY);
    @(negedge clk);
    chk("zero_idle_done", {31'd0, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
